// File: rtl/nbody_pkg.sv
// Shared types and latency constants for the n-body acceleration datapath.
// The getAccl stage latencies here set the depth of the result tag line.
package nbody_pkg;

   localparam int NMAX = 1024;
   localparam int IDXW = $clog2(NMAX);

   localparam int MULT_TIME    = 14;
   localparam int ADD_TIME     = 11;
   localparam int INVSQRT_TIME = 30;

   // Operands at the getAccl inputs to the matching ax/ay at its outputs.
   localparam int PIPE_LAT_DEFAULT = 1 + 2 * ADD_TIME + 5 * MULT_TIME + INVSQRT_TIME;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_I = 2'd1,
      ISSUE  = 2'd2,
      DRAIN  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic            valid;
      logic [IDXW-1:0] idx;
      logic            last;
   } tag_t;

endpackage

// File: rtl/accel_sequencer_tag_delay.sv
// Fixed-depth shift line carrying result tags alongside the getAccl pipeline.
// valid_cnt is the number of valid tags currently held in the line.
module tag_delay
   import nbody_pkg::*;
#(
   parameter int LAT  = PIPE_LAT_DEFAULT,
   parameter int CNTW = $clog2(LAT + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  tag_t            tag_in,
   output tag_t            tag_out,
   output logic [CNTW-1:0] valid_cnt
);

   tag_t            line_q [LAT];
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNTW'(tag_in.valid) - CNTW'(line_q[LAT-1].valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            line_q[k] <= '0;
         end
         cnt_q <= '0;
      end else begin
         line_q[0] <= tag_in;
         for (int k = 1; k < LAT; k++) begin
            line_q[k] <= line_q[k-1];
         end
         cnt_q <= cnt_d;
      end
   end

   assign tag_out   = line_q[LAT-1];
   assign valid_cnt = cnt_q;

endmodule

// File: rtl/accel_sequencer.sv
// Walks every (i, j) body pair into getAccl, one pair per cycle, and tags each ax/ay result.
// Build macro SKIP_SELF_EN: when defined, j == i pairs are neither read nor issued.
module accel_sequencer
   import nbody_pkg::*;
#(
   parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IDXW:0]   n_bodies,
   output logic            busy,
   output logic            done,
   output logic            rd_en,
   output logic [IDXW-1:0] rd_addr,
   input  logic [63:0]     rd_x,
   input  logic [63:0]     rd_y,
   input  logic [63:0]     rd_m,
   output logic [63:0]     x1,
   output logic [63:0]     y1,
   output logic [63:0]     x2,
   output logic [63:0]     y2,
   output logic [63:0]     m2,
   input  logic [63:0]     ax_in,
   input  logic [63:0]     ay_in,
   output logic            res_valid,
   output logic [IDXW-1:0] res_i,
   output logic            res_last,
   output logic [63:0]     res_ax,
   output logic [63:0]     res_ay,
   output seq_state_e      dbg_state
);

   localparam int            CNTW   = $clog2(PIPE_LAT + 1);
   localparam logic [IDXW:0] NMAX_W = (IDXW + 1)'(NMAX);

   seq_state_e      state_q, state_d;
   logic [IDXW:0]   n_q, n_d;
   logic [IDXW-1:0] i_q, i_d;
   logic [IDXW-1:0] j_q, j_d;
   logic            phase_q, phase_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [63:0]     x1_q, x1_d, y1_q, y1_d;
   logic [63:0]     x2_q, y2_q, m2_q;
   tag_t            ret_q, ret_d;
   tag_t            push_q;
   logic            res_valid_q, res_last_q;
   logic [IDXW-1:0] res_i_q;
   logic [63:0]     res_ax_q, res_ay_q;

   tag_t            tag_out;
   logic [CNTW-1:0] valid_cnt;

   logic [IDXW:0]   n_sat;
   logic [IDXW:0]   n_last;
   logic [IDXW:0]   j_last_idx;
   logic [IDXW-1:0] j_first;
   logic [IDXW-1:0] j_next;
   logic            i_last;
   logic            j_last;
   logic            line_busy;

   assign n_sat  = (n_bodies > NMAX_W) ? NMAX_W : n_bodies;
   assign n_last = n_q - (IDXW + 1)'(1);
   assign i_last = ({1'b0, i_q} == n_last);

`ifdef SKIP_SELF_EN
   logic [IDXW-1:0] j_inc;
   assign j_inc      = j_q + IDXW'(1);
   assign j_next     = (j_inc == i_q) ? j_q + IDXW'(2) : j_inc;
   assign j_first    = (i_q == '0) ? IDXW'(1) : '0;
   assign j_last_idx = i_last ? n_q - (IDXW + 1)'(2) : n_last;
`else
   assign j_next     = j_q + IDXW'(1);
   assign j_first    = '0;
   assign j_last_idx = n_last;
`endif

   assign j_last = ({1'b0, j_q} == j_last_idx);

   // Only the emerging entry (already being registered into res_*) may remain.
   assign line_busy = ret_q.valid | push_q.valid | (valid_cnt > CNTW'(tag_out.valid));

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      j_d     = j_q;
      phase_d = phase_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      x1_d    = x1_q;
      y1_d    = y1_q;
      ret_d   = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (n_sat != '0) begin
                  n_d     = n_sat;
                  i_d     = '0;
                  phase_d = 1'b0;
                  busy_d  = 1'b1;
                  state_d = LOAD_I;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         LOAD_I: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               x1_d    = rd_x;
               y1_d    = rd_y;
               phase_d = 1'b0;
               j_d     = j_first;
               state_d = ISSUE;
`ifdef SKIP_SELF_EN
               if (n_q == (IDXW + 1)'(1)) begin
                  state_d = DRAIN;
               end
`endif
            end
         end
         ISSUE: begin
            ret_d.valid = 1'b1;
            ret_d.idx   = i_q;
            ret_d.last  = j_last;
            j_d         = j_next;
            if (j_last) begin
               if (i_last) begin
                  state_d = DRAIN;
               end else begin
                  i_d     = i_q + IDXW'(1);
                  state_d = LOAD_I;
               end
            end
         end
         DRAIN: begin
            if (!line_busy) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      if (state_q == LOAD_I && !phase_q) begin
         rd_en   = 1'b1;
         rd_addr = i_q;
      end else if (state_q == ISSUE) begin
         rd_en   = 1'b1;
         rd_addr = j_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         n_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         phase_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         x1_q        <= '0;
         y1_q        <= '0;
         x2_q        <= '0;
         y2_q        <= '0;
         m2_q        <= '0;
         ret_q       <= '0;
         push_q      <= '0;
         res_valid_q <= 1'b0;
         res_i_q     <= '0;
         res_last_q  <= 1'b0;
         res_ax_q    <= '0;
         res_ay_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         j_q     <= j_d;
         phase_q <= phase_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         ret_q   <= ret_d;
         // RAM data returns the cycle after an issue read; operands and tag appear together.
         if (ret_q.valid) begin
            x2_q <= rd_x;
            y2_q <= rd_y;
            m2_q <= rd_m;
         end
         push_q      <= ret_q;
         res_valid_q <= tag_out.valid;
         res_i_q     <= tag_out.idx;
         res_last_q  <= tag_out.last;
         res_ax_q    <= ax_in;
         res_ay_q    <= ay_in;
      end
   end

   tag_delay #(
      .LAT  (PIPE_LAT),
      .CNTW (CNTW)
   ) u_tag_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .tag_in    (push_q),
      .tag_out   (tag_out),
      .valid_cnt (valid_cnt)
   );

   // res_valid is a strobe with no ready: every asserted cycle is one result the consumer must take.
   assign res_valid = res_valid_q;
   assign res_i     = res_i_q;
   assign res_last  = res_last_q;
   assign res_ax    = res_ax_q;
   assign res_ay    = res_ay_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign x1        = x1_q;
   assign y1        = y1_q;
   assign x2        = x2_q;
   assign y2        = y2_q;
   assign m2        = m2_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer: RAM model, getAccl stub (pure delay of x2/y2), result scoreboard.
// Honours SKIP_SELF_EN the same way as the design build.
`timescale 1ns/1ps
module tb_accel_sequencer;
   import nbody_pkg::*;

   localparam int L  = PIPE_LAT_DEFAULT;
   localparam int EW = IDXW + 1 + 128;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [IDXW:0]   n_bodies = '0;
   logic            busy, done, rd_en;
   logic [IDXW-1:0] rd_addr;
   logic [63:0]     rd_x = '0, rd_y = '0, rd_m = '0;
   logic [63:0]     x1, y1, x2, y2, m2;
   logic [63:0]     ax_in, ay_in;
   logic            res_valid, res_last;
   logic [IDXW-1:0] res_i;
   logic [63:0]     res_ax, res_ay;
   seq_state_e      dbg_state;

   logic [63:0]     ram_x [8];
   logic [63:0]     ram_y [8];
   logic [63:0]     ram_m [8];
   logic [63:0]     gx_q [L];
   logic [63:0]     gy_q [L];

   logic [EW-1:0]   exp_q [$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int res_cnt = 0, done_cnt = 0, rd_cnt = 0;
   int last_rd_cyc = 0, done_cyc = 0, last_res_cyc = 0;

   // Per-cycle RAM/operand expectations for an N=2 pass; cycle 1 is the first after start.
   // Operand selectors index ram_x; -1 means the reset value 0.
`ifdef SKIP_SELF_EN
   int prot_en   [10] = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0};
   int prot_addr [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
   int prot_x1   [10] = '{-1, -1, 0, 0, 0, 1, 1, 1, 1, 1};
   int prot_x2   [10] = '{-1, -1, -1, -1, 1, 1, 1, 0, 0, 0};
   int r1 = 0, r2 = 2, r3 = 6, r4 = 12;
`else
   int prot_en   [10] = '{1, 0, 1, 1, 1, 0, 1, 1, 0, 0};
   int prot_addr [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
   int prot_x1   [10] = '{-1, -1, 0, 0, 0, 0, 1, 1, 1, 1};
   int prot_x2   [10] = '{-1, -1, -1, -1, 0, 1, 1, 1, 0, 1};
   int r1 = 1, r2 = 4, r3 = 9, r4 = 16;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   accel_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .n_bodies  (n_bodies),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_m      (rd_m),
      .x1        (x1),
      .y1        (y1),
      .x2        (x2),
      .y2        (y2),
      .m2        (m2),
      .ax_in     (ax_in),
      .ay_in     (ay_in),
      .res_valid (res_valid),
      .res_i     (res_i),
      .res_last  (res_last),
      .res_ax    (res_ax),
      .res_ay    (res_ay),
      .dbg_state (dbg_state)
   );

   // Body RAM (1-cycle read) and getAccl stub echoing x2/y2 after L cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_x <= ram_x[rd_addr[2:0]];
         rd_y <= ram_y[rd_addr[2:0]];
         rd_m <= ram_m[rd_addr[2:0]];
      end
      gx_q[0] <= x2;
      gy_q[0] <= y2;
      for (int k = 1; k < L; k++) begin
         gx_q[k] <= gx_q[k-1];
         gy_q[k] <= gy_q[k-1];
      end
   end
   assign ax_in = gx_q[L-1];
   assign ay_in = gy_q[L-1];

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] sel_x(input int s);
      return (s < 0) ? 64'h0 : ram_x[s];
   endfunction

   // Scoreboard: every res_valid must match the head of exp_q.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n) begin
         if (rd_en) begin
            rd_cnt++;
            last_rd_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (res_valid) begin
            res_cnt++;
            last_res_cyc = cyc;
            if (exp_q.size() == 0) begin
               check_eq("res_unexpected", 64'(res_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check_eq("res_i", 64'(res_i), 64'(e[IDXW+128:129]));
               check_eq("res_last", 64'(res_last), 64'(e[128]));
               check_eq("res_ax", res_ax, e[127:64]);
               check_eq("res_ay", res_ay, e[63:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_ram(input real xb, input real yb, input real ys);
      for (int k = 0; k < 8; k++) begin
         ram_x[k] = $realtobits(xb + real'(k));
         ram_y[k] = $realtobits(yb + ys * real'(k));
         ram_m[k] = $realtobits(1.0);
      end
   endtask

   // Expected tagged stream: all pairs in (i, j) order, last flag on the final pair of each i.
   task automatic load_exp(input int n);
      logic [EW-1:0] tmp;
      for (int i = 0; i < n; i++) begin
         int pushed;
         pushed = 0;
         for (int j = 0; j < n; j++) begin
`ifdef SKIP_SELF_EN
            if (j == i) continue;
`endif
            exp_q.push_back({IDXW'(i), 1'b0, ram_x[j], ram_y[j]});
            pushed++;
         end
         if (pushed > 0) begin
            tmp = exp_q.pop_back();
            tmp[128] = 1'b1;
            exp_q.push_back(tmp);
         end
      end
   endtask

   task automatic run_pass(input int n, input string tag, input int n_res, input int mid_at,
                           input bit prot, input bit timing);
      int budget;
      bit seen;
      exp_q.delete();
      load_exp(n);
      res_cnt  = 0;
      done_cnt = 0;
      @(negedge clk);
      n_bodies = (IDXW + 1)'(n);
      start    = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      budget = n * (n + 2) + L + 40;
      seen   = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         start = (mid_at > 0 && k == mid_at);
         if (start) begin
            n_bodies = (IDXW + 1)'(2);
            check_eq({tag, "_mid_busy"}, 64'(busy), 64'(1));
         end
         if (prot && k < 10) begin
            check_eq("prot_rd_en", 64'(rd_en), 64'(prot_en[k]));
            if (prot_en[k] != 0) check_eq("prot_rd_addr", 64'(rd_addr), 64'(prot_addr[k]));
            check_eq("prot_x1", x1, sel_x(prot_x1[k]));
            check_eq("prot_x2", x2, sel_x(prot_x2[k]));
         end
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      start = 1'b0;
      check_eq({tag, "_done_seen"}, 64'(seen), 64'(1));
      repeat (4) @(negedge clk);
      check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
      check_eq({tag, "_res_cnt"}, 64'(res_cnt), 64'(n_res));
      check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'(0));
      check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
      if (timing) begin
         // Last issue read r: operands at r+2, result registered PIPE_LAT+1 later, done with it.
         check_eq({tag, "_done_lat"}, 64'(done_cyc - last_rd_cyc), 64'(L + 3));
         check_eq({tag, "_done_vs_last_res"}, 64'(done_cyc), 64'(last_res_cyc));
      end
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      load_ram(10.0, 20.0, 1.0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_done", 64'(done), 64'(0));
      check_eq("rst_rd_en", 64'(rd_en), 64'(0));
      check_eq("rst_res_valid", 64'(res_valid), 64'(0));
      check_eq("rst_x1", x1, 64'h0);
      check_eq("rst_x2", x2, 64'h0);
      check_eq("rst_m2", m2, 64'h0);
      check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-body start: done next cycle, no reads, never busy.
      rd_cnt   = 0;
      done_cnt = 0;
      n_bodies = '0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("zero_done", 64'(done), 64'(1));
      check_eq("zero_busy", 64'(busy), 64'(0));
      @(negedge clk);
      check_eq("zero_done_clr", 64'(done), 64'(0));
      check_eq("zero_busy2", 64'(busy), 64'(0));
      repeat (3) @(negedge clk);
      check_eq("zero_rd_cnt", 64'(rd_cnt), 64'(0));
      check_eq("zero_done_cnt", 64'(done_cnt), 64'(1));

      run_pass(2, "prot", r2, 0, 1'b1, 1'b0);

      load_ram(0.0, 0.0, 0.0);
      run_pass(3, "n3", r3, 0, 1'b0, 1'b1);
      run_pass(4, "mid", r4, 20, 1'b0, 1'b0);
      run_pass(1, "n1", r1, 0, 1'b0, 1'b0);

      // Reset in the middle of ISSUE: nothing may come out afterwards.
      res_cnt  = 0;
      done_cnt = 0;
      @(negedge clk);
      n_bodies = (IDXW + 1)'(5);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("pre_rst_rd_en", 64'(rd_en), 64'(1));
      check_eq("pre_rst_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_eq("in_rst_busy", 64'(busy), 64'(0));
      check_eq("in_rst_state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;
      repeat (L + 20) @(negedge clk);
      check_eq("post_rst_res_cnt", 64'(res_cnt), 64'(0));
      check_eq("post_rst_done_cnt", 64'(done_cnt), 64'(0));
      check_eq("post_rst_busy", 64'(busy), 64'(0));
      run_pass(2, "after_rst", r2, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/accel_sequencer.md
Name: accel_sequencer

Overview:
- Feeds the getAccl pairwise-acceleration pipeline at one body pair per cycle and collects its results.
- Walks every (i, j) body pair, reading positions and masses from the body RAM.
- Carries a valid/index tag alongside the pipeline and tags each ax/ay result as it emerges.
- Downstream force accumulators consume the tagged stream.

Parameters:
- NMAX, 1024, maximum body count; IDXW = $clog2(NMAX).
- PIPE_LAT, 123, cycles from operands at the getAccl inputs to the matching ax/ay (1 + 2*AddTime + 5*MultTime + InvSqrtTime).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a pass
- n_bodies  in  IDXW+1  body count, latched on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the pass has fully drained
- rd_en  out  1  body RAM read enable
- rd_addr  out  IDXW  body RAM address
- rd_x, rd_y, rd_m  in  64 each  RAM data, valid 1 cycle after rd_en
- x1, y1, x2, y2, m2  out  64 each  registered operands to getAccl
- ax_in, ay_in  in  64 each  getAccl results
- res_valid  out  1  result strobe
- res_i  out  IDXW  target body index of the result
- res_last  out  1  final result for res_i
- res_ax, res_ay  out  64 each  ax_in/ay_in registered, aligned with the tag

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, tag line cleared.
- States:
  - IDLE: start with n_bodies > 0 latches N, sets i = 0 and goes to LOAD_I. start with n_bodies = 0 pulses done the next cycle and stays in IDLE.
  - LOAD_I: cycle 1 reads addr i. Cycle 2 captures x1, y1 from RAM data, sets j = 0 and goes to ISSUE.
  - ISSUE: reads addr j every cycle, j++. Each RAM return drives x2, y2, m2 and pushes tag {valid=1, i, last=(j==N-1)} into the delay line the same cycle the operands appear. After returning j = N-1: if i == N-1 go to DRAIN, else i++ and go to LOAD_I.
  - DRAIN: waits until the tag line holds no valid entry, then pulses done and returns to IDLE.
- Non-issue cycles push an invalid tag; x2, y2, m2 hold their previous values.
- Tag timing: a tag pushed at cycle t emerges at t+PIPE_LAT. res_* are registered from the emerging tag and ax_in/ay_in, so result latency from push is PIPE_LAT+1 cycles.
- Throughput: N pairs per i with a 2-cycle bubble per i. Total issue time is N*(N+2) cycles, plus drain.
- No backpressure: the consumer must accept every res_valid.
- start while busy is ignored. n_bodies > NMAX saturates to NMAX.
- Operands pass through unmodified; no arithmetic is done on FP values. Self-pair handling belongs to getAccl, which zeroes the mass.
- Reset mid-pass: everything clears immediately, in-flight results are discarded and no done is produced.

Optional Feature:
- Macro SKIP_SELF_EN.
- Defined: ISSUE does not read or issue j == i; j steps past i. res_last marks the last j != i. N = 1 issues nothing and goes straight from LOAD_I to DRAIN. Each i costs N-1 issue cycles.
- Undefined: self pairs are issued and tagged as normal.

Decomposition:
- Package nbody_pkg:
  - MULT_TIME, ADD_TIME, INVSQRT_TIME constants.
  - Derived PIPE_LAT_DEFAULT.
  - State enum {IDLE, LOAD_I, ISSUE, DRAIN}.
  - Packed tag struct {valid, idx, last}.
- Sub-module tag_delay: a PIPE_LAT-deep shift of the tag struct with an asynchronous active-low clear. It also outputs a live count of valid entries used for the DRAIN exit.

Test Plan:
- N=3, RAM x = {0, 1.0, 2.0}, y = 0, m = 1.0, stub getAccl as a PIPE_LAT delay of x2 → 9 res_valid.
  - res_i sequence is 0,0,0,1,1,1,2,2,2.
  - res_last is high on the 3rd, 6th and 9th results.
  - res_ax equals the echoed x2 sequence.
  - done fires exactly PIPE_LAT+1 cycles after the last issue.
- start with n_bodies = 0 → done one cycle later, no rd_en, busy stays low.
- Pulse start again mid-pass with N=4 → ignored; exactly 16 results and one done.
- Assert rst_n low during ISSUE with N=5, release after 3 cycles → no res_valid, no done; busy = 0; a new start then completes normally.
- SKIP_SELF_EN defined, N=3 → 6 results with (i,j) = (0,1),(0,2),(1,0),(1,2),(2,0),(2,1). N=1 → zero results, done still pulses.
- Check the RAM protocol: rd_addr sequence for N=2 is 0 (LOAD_I), 0, 1 (ISSUE), 1 (LOAD_I), 0, 1, and operands change only one cycle after each read.
